// File: rtl/id_scoreboard.sv
// id_scoreboard
//   Register-hazard scoreboard for the ID stage against the 32-entry integer
//   register file. Each architectural register has a pending-write counter.
//   An accepted issue that writes rd increments the counter, and a writeback
//   decrements it. issue_ready drops while a source register has a write in
//   flight, while rd's counter is saturated, or while the global outstanding
//   limit is reached.
//
//   Optional feature macro: SCOREBOARD_BYPASS_EN
//     When defined, a same-cycle writeback to a source register with exactly
//     one pending write hides the RAW hazard on that source, because EX
//     forwards the writeback data.
//
// Ports
//   clk          clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   issue_valid  ID presents a decoded instruction
//   issue_ready  no hazard; instruction may issue this cycle
//   rs1_r_ena/rs1_r_addr, rs2_r_ena/rs2_r_addr   source operand reads
//   rd_w_ena/rd_w_addr                           destination write
//   wb_valid/wb_addr                             writeback retiring one write
//   flush        synchronous clear of all pending state (wb_err kept)
//   stall        issue_valid & ~issue_ready
//   busy         bit i set while register i has a pending write (bit 0 = 0)
//   out_cnt      total outstanding writes, 0..MAX_OUT
//   wb_err       sticky flag: writeback with nothing outstanding
module id_scoreboard #(
  parameter int CNT_W   = 2,
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        rs1_r_ena,
  input  logic [4:0]  rs1_r_addr,
  input  logic        rs2_r_ena,
  input  logic [4:0]  rs2_r_addr,
  input  logic        rd_w_ena,
  input  logic [4:0]  rd_w_addr,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] busy,
  output logic [2:0]  out_cnt,
  output logic        wb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [2:0]       OUT_MAX = 3'(MAX_OUT);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [2:0]       out_cnt_q, out_cnt_d;
  logic             wb_err_q, wb_err_d;

  logic raw1, raw2, waw_full, out_full;
  logic byp1, byp2;
  logic inc_en, dec_en, wb_bad;

  // Hazard detection, purely from current state (issue_valid is not used,
  // so there is no path from issue_valid back to issue_ready).
  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
    // Only a count of exactly one is hidden: with more writes in flight the
    // retiring one is not the youngest value.
    byp1 = wb_valid && (wb_addr == rs1_r_addr) && (cnt_q[rs1_r_addr] == CNT_W'(1));
    byp2 = wb_valid && (wb_addr == rs2_r_addr) && (cnt_q[rs2_r_addr] == CNT_W'(1));
`endif
    raw1     = rs1_r_ena && (rs1_r_addr != 5'd0) && (cnt_q[rs1_r_addr] != '0) && !byp1;
    raw2     = rs2_r_ena && (rs2_r_addr != 5'd0) && (cnt_q[rs2_r_addr] != '0) && !byp2;
    // Limits use pre-writeback state even with bypass compiled in.
    waw_full = rd_w_ena && (rd_w_addr != 5'd0) && (cnt_q[rd_w_addr] == CNT_MAX);
    out_full = rd_w_ena && (rd_w_addr != 5'd0) && (out_cnt_q == OUT_MAX);
  end

  assign issue_ready = !(raw1 || raw2 || waw_full || out_full);
  assign stall       = issue_valid && !issue_ready;

  assign inc_en = issue_valid && issue_ready && rd_w_ena && (rd_w_addr != 5'd0);
  assign dec_en = wb_valid && (wb_addr != 5'd0) && (cnt_q[wb_addr] != '0);
  assign wb_bad = wb_valid && ((wb_addr == 5'd0) ? (out_cnt_q == 3'd0)
                                                 : (cnt_q[wb_addr] == '0));

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    out_cnt_d = out_cnt_q;
    wb_err_d  = wb_err_q || wb_bad;

    // x0 is never tracked; its counter stays zero.
    for (int i = 1; i < 32; i++) begin
      if (inc_en && (rd_w_addr == 5'(i))) cnt_d[i] = cnt_d[i] + CNT_W'(1);
      if (dec_en && (wb_addr == 5'(i)))   cnt_d[i] = cnt_d[i] - CNT_W'(1);
    end
    // Same-register inc/dec cancel above; out_cnt only moves on a net change.
    if (inc_en && !dec_en) out_cnt_d = out_cnt_q + 3'd1;
    if (!inc_en && dec_en) out_cnt_d = out_cnt_q - 3'd1;

    if (flush) begin
      for (int i = 0; i < 32; i++) begin
        cnt_d[i] = '0;
      end
      out_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= '0;
      end
      out_cnt_q <= 3'd0;
      wb_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      out_cnt_q <= out_cnt_d;
      wb_err_q  <= wb_err_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 1; i < 32; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
  end

  assign out_cnt = out_cnt_q;
  assign wb_err  = wb_err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_ready;
  logic        rs1_r_ena, rs2_r_ena, rd_w_ena, wb_valid, flush;
  logic [4:0]  rs1_r_addr, rs2_r_addr, rd_w_addr, wb_addr;
  logic        stall, wb_err;
  logic [31:0] busy;
  logic [2:0]  out_cnt;

  int n_vec = 0;
  int n_bad = 0;

  id_scoreboard #(.CNT_W(2), .MAX_OUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs1_r_ena(rs1_r_ena), .rs1_r_addr(rs1_r_addr),
    .rs2_r_ena(rs2_r_ena), .rs2_r_addr(rs2_r_addr),
    .rd_w_ena(rd_w_ena), .rd_w_addr(rd_w_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .flush(flush), .stall(stall), .busy(busy),
    .out_cnt(out_cnt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        r1e;
    logic [4:0]  r1;
    logic        r2e;
    logic [4:0]  r2;
    logic        rde;
    logic [4:0]  rd;
    logic        wbv;
    logic [4:0]  wba;
    logic        fl;
    logic        rdy;      // issue_ready in this cycle, no bypass
    logic        rdy_byp;  // issue_ready in this cycle, bypass build
    logic [31:0] busy;     // state after the edge
    logic [2:0]  oc;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] busy;
    logic [2:0]  oc;
    logic        err;
    int          idx;
  } post_t;

  vec_t  vt[$];
  post_t sb[$];

  function automatic vec_t mk(bit iv, bit r1e, int r1, bit r2e, int r2, bit rde, int rd,
                              bit wbv, int wba, bit fl, bit rdy, bit rdyb,
                              int bsy, int oc, bit err);
    vec_t v;
    v.iv = iv; v.r1e = r1e; v.r1 = 5'(r1); v.r2e = r2e; v.r2 = 5'(r2);
    v.rde = rde; v.rd = 5'(rd); v.wbv = wbv; v.wba = 5'(wba); v.fl = fl;
    v.rdy = rdy; v.rdy_byp = rdyb; v.busy = 32'(bsy); v.oc = 3'(oc); v.err = err;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    issue_valid = 0; rs1_r_ena = 0; rs1_r_addr = 0; rs2_r_ena = 0; rs2_r_addr = 0;
    rd_w_ena = 0; rd_w_addr = 0; wb_valid = 0; wb_addr = 0; flush = 0;
  endtask

  initial begin
    //            iv r1e r1 r2e r2 rde rd wbv wba fl rdy rdyb busy        oc err
    vt.push_back(mk(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 1, 1, 32'h0000_0040, 1, 0)); // 0
    vt.push_back(mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0040, 1, 0)); // 1 RAW x6
    vt.push_back(mk(1, 1, 6, 0, 0, 0, 0, 1, 6, 0, 0, 1, 32'h0000_0000, 0, 0)); // 2 wb x6
    vt.push_back(mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0000, 0, 0)); // 3
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 1, 32'h0000_0080, 1, 0)); // 4 rd7 #1
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 1, 32'h0000_0080, 2, 0)); // 5 rd7 #2
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 1, 32'h0000_0080, 3, 0)); // 6 rd7 #3
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 32'h0000_0080, 3, 0)); // 7 waw_full
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 0, 0, 32'h0000_0080, 2, 0)); // 8 still full
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 1, 32'h0000_0080, 3, 0)); // 9
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 1, 32'h0000_0080, 2, 0)); // 10
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 1, 32'h0000_0080, 1, 0)); // 11
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 1, 32'h0000_0000, 0, 0)); // 12
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 32'h0000_0002, 1, 0)); // 13
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 1, 32'h0000_0006, 2, 0)); // 14
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 1, 32'h0000_000E, 3, 0)); // 15
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 1, 32'h0000_001E, 4, 0)); // 16
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 32'h0000_001E, 4, 0)); // 17 out_full
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 9, 1, 1, 0, 0, 0, 32'h0000_001C, 3, 0)); // 18 still full
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 1, 1, 32'h0000_021C, 4, 0)); // 19
    vt.push_back(mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 32'h0000_021C, 4, 0)); // 20 x0 only
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,10, 0, 1, 1, 32'h0000_021C, 4, 1)); // 21 bad wb
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 1, 32'h0000_0218, 3, 1)); // 22
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 1, 1, 32'h0000_0018, 2, 1)); // 23
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 1, 1, 1, 32'h0000_0000, 0, 1)); // 24 flush
    vt.push_back(mk(1, 0, 0, 1, 3, 1, 5, 0, 0, 0, 1, 1, 32'h0000_0020, 1, 1)); // 25
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 5, 1, 5, 0, 1, 1, 32'h0000_0020, 1, 1)); // 26 same reg
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 8, 1, 5, 0, 1, 1, 32'h0000_0100, 1, 1)); // 27 diff reg
    vt.push_back(mk(1, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0100, 1, 1)); // 28 RAW rs2
    vt.push_back(mk(1, 0, 8, 0, 8, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0100, 1, 1)); // 29 ena low
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 32'h0000_0100, 1, 1)); // 30 wb x0 ok
    vt.push_back(mk(0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0100, 1, 1)); // 31 no valid
    vt.push_back(mk(0, 0, 0, 0, 0, 1,12, 0, 0, 0, 1, 1, 32'h0000_0100, 1, 1)); // 32 no accept

    drive_idle();
    issue_valid = 1;
    rst_n = 0;
    #1;
    chk("reset_busy",    busy, 32'h0);
    chk("reset_out_cnt", 32'(out_cnt), 32'h0);
    chk("reset_wb_err",  32'(wb_err), 32'h0);
    chk("reset_ready",   32'(issue_ready), 32'h1);
    chk("reset_stall",   32'(stall), 32'h0);

    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < vt.size(); i++) begin
      post_t p;
      logic  er;
      @(negedge clk);
      issue_valid = vt[i].iv;
      rs1_r_ena = vt[i].r1e; rs1_r_addr = vt[i].r1;
      rs2_r_ena = vt[i].r2e; rs2_r_addr = vt[i].r2;
      rd_w_ena  = vt[i].rde; rd_w_addr  = vt[i].rd;
      wb_valid  = vt[i].wbv; wb_addr    = vt[i].wba;
      flush     = vt[i].fl;
`ifdef SCOREBOARD_BYPASS_EN
      er = vt[i].rdy_byp;
`else
      er = vt[i].rdy;
`endif
      #1;
      chk($sformatf("v%0d_ready", i), 32'(issue_ready), 32'(er));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vt[i].iv & ~er));
      p.busy = vt[i].busy; p.oc = vt[i].oc; p.err = vt[i].err; p.idx = i;
      sb.push_back(p);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'(sb.size()), 32'h1);
      end else begin
        p = sb.pop_front();
        chk($sformatf("v%0d_busy", p.idx),    busy, p.busy);
        chk($sformatf("v%0d_out_cnt", p.idx), 32'(out_cnt), 32'(p.oc));
        chk($sformatf("v%0d_wb_err", p.idx),  32'(wb_err), 32'(p.err));
      end
    end

    // Asynchronous reset in the middle of a low clock phase, x8 still pending.
    @(negedge clk);
    drive_idle();
    issue_valid = 1; rs1_r_ena = 1; rs1_r_addr = 5'd8;
    #1;
    chk("pre_rst_ready", 32'(issue_ready), 32'h0);
    chk("pre_rst_stall", 32'(stall), 32'h1);
    #1;
    rst_n = 0;
    #1;
    chk("async_rst_busy",    busy, 32'h0);
    chk("async_rst_out_cnt", 32'(out_cnt), 32'h0);
    chk("async_rst_wb_err",  32'(wb_err), 32'h0);
    chk("async_rst_ready",   32'(issue_ready), 32'h1);
    chk("async_rst_stall",   32'(stall), 32'h0);

    // Writeback to x0 with nothing outstanding is an error.
    @(negedge clk);
    rst_n = 1;
    drive_idle();
    wb_valid = 1; wb_addr = 5'd0;
    @(posedge clk);
    #1;
    chk("wb_x0_empty_err", 32'(wb_err), 32'h1);
    chk("wb_x0_empty_cnt", 32'(out_cnt), 32'h0);
    @(negedge clk);
    drive_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
